button_frontend: RTL and testbench
==================================

Name: button_frontend

Overview:
- Producer end of the left/right/put move interface consumed by the game state logic.
- Takes raw, asynchronous, bouncing board push-buttons and synchronises and debounces them.
- Emits clean single-cycle move pulses, with at most one move pulse per cycle.
- Sits between board pins and the game top level; the game logic sees only its outputs.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a press or release (5 ms at 50 MHz); minimum 2
REPEAT_DELAY, 25000000, cycles a left/right must stay held before the first auto-repeat pulse (auto-repeat builds only)
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (auto-repeat builds only)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
left_raw  input  1  raw left button, active-high, asynchronous to clk
right_raw  input  1  raw right button, active-high, asynchronous to clk
put_raw  input  1  raw put button, active-high, asynchronous to clk
left  output  1  one-cycle pulse: move selector one column left
right  output  1  one-cycle pulse: move selector one column right
put  output  1  one-cycle pulse: drop piece in selected column
held  output  3  debounced level per button {put,right,left}, for status LEDs

Behaviour:
- Reset: async assert. All synchronisers, counters, outputs and held go to 0. Every channel FSM goes to IDLE. Deassertion is taken synchronously on the next clk edge.
- Synchroniser: 2-flop chain per raw input. s = second flop.
- Per-channel FSM states and transitions:
  - IDLE: s=1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: counter increments while s=1. If s=0 -> IDLE; the counter clears, so bounces restart the count. When the counter reaches DEBOUNCE_CYCLES-1 with s=1 -> HELD, and the channel raises its press event.
  - HELD: s=0 -> RELEASE_WAIT.
  - RELEASE_WAIT: symmetric to PRESS_WAIT with s=0. If s=1 -> HELD, with no new event. Completion -> IDLE.
- held[i] = 1 in HELD and RELEASE_WAIT.
- Latency: raw held high from edge 0. Sync output s is high at edge 2. HELD is entered at edge DEBOUNCE_CYCLES+1. The registered output pulse is high for exactly one cycle after edge DEBOUNCE_CYCLES+2.
- Arbitration, same cycle:
  - Only a put event -> put pulse.
  - Left and right events together -> both dropped, no pulse.
  - Put with left or right -> put wins; the left/right event is dropped, not queued.
  - Dropped events never reappear.
- Counter width: $clog2 of the largest active parameter. Counters saturate and never wrap.
- A button held indefinitely produces exactly one pulse (non-repeat build).
- Raw glitch shorter than DEBOUNCE_CYCLES: no pulse, held stays 0.
- Reset mid-debounce or mid-hold: the channel restarts from IDLE. No pulse is produced for a button already down at reset release until it completes a full PRESS_WAIT.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - left/right channels in HELD run a repeat counter.
  - The first repeat event fires REPEAT_DELAY cycles after entry to HELD. Subsequent repeat events fire every REPEAT_PERIOD cycles while the channel remains in HELD.
  - RELEASE_WAIT pauses the repeat counter. Return to HELD resumes it. Reaching IDLE clears it.
  - Repeat events go through the same arbitration.
  - put never repeats.
- Undefined: no repeat counters or logic are synthesised, and REPEAT_* are ignored.

Decomposition:
- Package score4_input_pkg:
  - enum btn_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
  - Localparam channel indices BTN_LEFT=0, BTN_RIGHT=1, BTN_PUT=2.
  - Counter-width helper function.
- Sub-module button_debounce (sync + FSM + optional repeat, one channel): instantiated 3 times. Arbitration and output registers live in button_frontend.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- left_raw 0->1 at edge 0, held 50 cycles -> left pulses only after edge 6. held[0] rises at edge 5. No repeat build: no further pulses.
- put_raw bounces 1,0,1,1,0 then steady 1 -> exactly one put pulse, 6 edges after the start of the steady run. A 3-cycle glitch gives no pulse.
- left_raw and right_raw rise on the same edge -> no left/right pulse. held=3'b011.
- put_raw and right_raw rise together -> single put pulse, right dropped.
- BTN_AUTOREPEAT_EN: right held 60 cycles -> pulses at the initial slot, then +20, +28, +36, +44, +52 cycles. A release bounce shorter than 4 cycles does not restart the delay.
- rst pulsed asynchronously mid PRESS_WAIT with left_raw still high -> outputs 0 immediately. After release, a pulse follows DEBOUNCE_CYCLES+2 edges later.

Source files
------------

// File: rtl/button_frontend_pkg.sv
// Shared types and helpers for the push-button front end.
// Channel indices, per-channel FSM state encoding and counter sizing.
package score4_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_PUT   = 2;
  localparam int NUM_BTN   = 3;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to count up to (largest - 1); never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned largest);
    return (largest < 2) ? 1 : $clog2(largest);
  endfunction

endpackage

// File: rtl/button_frontend_if.sv
// Move interface between the button front end (master) and game logic (slave).
interface button_frontend_if;
  logic       left;
  logic       right;
  logic       put;
  logic [2:0] held;

  modport master (output left, right, put, held);
  modport slave  (input  left, right, put, held);
endinterface

// File: rtl/button_frontend_debounce.sv
// One button channel: 2-flop synchroniser, debounce FSM and, in builds with
// BTN_AUTOREPEAT_EN defined, a hold-to-repeat counter.
// o_event is a registered single-cycle pulse; o_held is the debounced level.
import score4_input_pkg::*;

module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
`ifdef BTN_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_DELAY  = 25000000
  , parameter int unsigned REPEAT_PERIOD = 10000000
  , parameter bit          REPEAT_EN     = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_held,
  output logic o_event
);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned CNT_W =
    cnt_width(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
`else
  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
`endif

  // The transition fires on the stable sample that brings the count to
  // DEBOUNCE_CYCLES-1, so compare against the value one below that.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [1:0]       r_sync;
  logic             w_s;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_held;
  logic             r_event;
`ifdef BTN_AUTOREPEAT_EN
  logic [CNT_W-1:0] r_rpt_cnt;
  logic             r_rpt_first;
`endif

  // Bring the asynchronous pin into the clk domain.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // with = the second stage would copy the first in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], i_raw};
  end

  assign w_s = r_sync[1];

  // Debounce FSM with registered held level, press/repeat event and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_held      <= 1'b0;
      r_event     <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
`endif
    end else begin
      r_event <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
`ifdef BTN_AUTOREPEAT_EN
          r_rpt_cnt   <= '0;
          r_rpt_first <= 1'b1;
`endif
          if (w_s) r_state <= PRESS_WAIT;
        end

        PRESS_WAIT: begin
          if (!w_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt >= DB_LAST) begin
            r_state <= HELD;
            r_cnt   <= '0;
            r_held  <= 1'b1;
            r_event <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
`endif
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        HELD: begin
          if (!w_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          // Repeat time only accumulates while the button stays down.
          else if (REPEAT_EN) begin
            if (r_rpt_cnt >= (r_rpt_first ? RPT_FIRST : RPT_NEXT)) begin
              r_event     <= 1'b1;
              r_rpt_cnt   <= '0;
              r_rpt_first <= 1'b0;
            end else if (r_rpt_cnt != '1) begin
              r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
          end
`endif
        end

        RELEASE_WAIT: begin
          if (w_s) begin
            // Release bounce: back to HELD silently, repeat timing resumes.
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt >= DB_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign o_held  = r_held;
  assign o_event = r_event;

endmodule

// File: rtl/button_frontend.sv
// Button front end: three debounced channels (left, right, put) feeding a
// same-cycle arbiter that emits at most one registered move pulse per cycle.
// Optional build macro: BTN_AUTOREPEAT_EN (hold-to-repeat on left/right).
import score4_input_pkg::*;

module button_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              left_raw,
  input  logic              right_raw,
  input  logic              put_raw,
  button_frontend_if.master bus
);

  // Elaboration-time guard on parameter ranges.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_frontend: DEBOUNCE_CYCLES must be >= 2, REPEAT_* >= 1");
  end

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_event;
  logic [NUM_BTN-1:0] w_held;
  logic               r_left;
  logic               r_right;
  logic               r_put;

  assign w_raw[BTN_LEFT]  = left_raw;
  assign w_raw[BTN_RIGHT] = right_raw;
  assign w_raw[BTN_PUT]   = put_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      , .REPEAT_DELAY  (REPEAT_DELAY)
      , .REPEAT_PERIOD (REPEAT_PERIOD)
      , .REPEAT_EN     (i != BTN_PUT)
`endif
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (w_raw[i]),
      .o_held  (w_held[i]),
      .o_event (w_event[i])
    );
  end

  // Arbitrate same-cycle events: put wins, left+right cancel, losers dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_put   <= 1'b0;
    end else begin
      r_put   <= w_event[BTN_PUT];
      r_left  <= w_event[BTN_LEFT]  & ~w_event[BTN_RIGHT] & ~w_event[BTN_PUT];
      r_right <= w_event[BTN_RIGHT] & ~w_event[BTN_LEFT]  & ~w_event[BTN_PUT];
    end
  end

  assign bus.left  = r_left;
  assign bus.right = r_right;
  assign bus.put   = r_put;
  assign bus.held  = w_held;

endmodule

// File: tb/tb_button_frontend.sv
// Directed bench for button_frontend with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Edge 0 is the first rising edge that samples a new raw
// level; "after edge n" means sampled on the falling edge following it.
module tb_button_frontend;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic left_raw = 1'b0, right_raw = 1'b0, put_raw = 1'b0;

  button_frontend_if bus ();

  button_frontend #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .left_raw  (left_raw),
    .right_raw (right_raw),
    .put_raw   (put_raw),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int e_now  = 0;
  int base   = 0;
  int n_left, n_right, n_put;
  int last_put;
  logic [2:0] held_or;
  int right_edges[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_left = 0; n_right = 0; n_put = 0;
    last_put = -1;
    held_or = 3'b000;
    right_edges.delete();
  endtask

  // Advance one rising edge, then observe outputs on the falling edge.
  task automatic tick();
    @(posedge clk);
    e_now++;
    @(negedge clk);
    n_left  += int'(bus.left);
    n_right += int'(bus.right);
    n_put   += int'(bus.put);
    if (bus.put)   last_put = e_now;
    if (bus.right) right_edges.push_back(e_now);
    held_or |= bus.held;
  endtask

  task automatic idle_out(input int n);
    left_raw = 1'b0; right_raw = 1'b0; put_raw = 1'b0;
    repeat (n) tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    logic b_seq [5];
    int   exp_rpt [6];
    int   exp_bnc [3];
    b_seq   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_rpt = '{6, 26, 34, 42, 50, 58};
    exp_bnc = '{6, 29, 37};

    // Reset state
    clear_counts();
    repeat (2) tick();
    check("rst_held",  32'(bus.held),  0);
    check("rst_left",  32'(bus.left),  0);
    check("rst_right", 32'(bus.right), 0);
    check("rst_put",   32'(bus.put),   0);
    rst = 1'b0;
    repeat (3) tick();

    // Single left press held 50 cycles
    clear_counts();
    left_raw = 1'b1;
    base = e_now + 1;
    repeat (5) tick();
    check("l_held_e4", 32'(bus.held), 3'b000);
    tick();
    check("l_held_e5", 32'(bus.held), 3'b001);
    check("l_pulse_e5", 32'(bus.left), 0);
    tick();
    check("l_pulse_e6", 32'(bus.left), 1);
    tick();
    check("l_pulse_e7", 32'(bus.left), 0);
    repeat (42) tick();
    idle_out(12);
    check("l_released", 32'(bus.held), 0);
`ifdef BTN_AUTOREPEAT_EN
    check("l_count", 32'(n_left), 5);
`else
    check("l_count", 32'(n_left), 1);
`endif
    check("l_no_right", 32'(n_right), 0);
    check("l_no_put",   32'(n_put),   0);

    // Put with press bounce, then steady
    clear_counts();
    base = e_now + 1;
    for (int i = 0; i < 5; i++) begin
      put_raw = b_seq[i];
      tick();
    end
    put_raw = 1'b1;
    repeat (15) tick();
    check("p_bounce_count", 32'(n_put), 1);
    check("p_bounce_edge",  32'(last_put - base), 11);
    idle_out(12);
    check("p_released", 32'(bus.held), 0);

    // 3-cycle put glitch
    clear_counts();
    put_raw = 1'b1;
    repeat (3) tick();
    idle_out(15);
    check("glitch_count", 32'(n_put), 0);
    check("glitch_held",  32'(held_or), 0);

    // Left and right together cancel
    clear_counts();
    left_raw = 1'b1; right_raw = 1'b1;
    repeat (6) tick();
    check("lr_held", 32'(bus.held), 3'b011);
    repeat (10) tick();
    check("lr_left",  32'(n_left),  0);
    check("lr_right", 32'(n_right), 0);
    idle_out(12);

    // Put and right together: put wins
    clear_counts();
    put_raw = 1'b1; right_raw = 1'b1;
    repeat (6) tick();
    check("pr_held", 32'(bus.held), 3'b110);
    repeat (10) tick();
    check("pr_put",   32'(n_put),   1);
    check("pr_right", 32'(n_right), 0);
    idle_out(12);

`ifdef BTN_AUTOREPEAT_EN
    // Auto-repeat on right held 60 cycles
    clear_counts();
    right_raw = 1'b1;
    base = e_now + 1;
    repeat (60) tick();
    idle_out(12);
    check("rpt_count", 32'(right_edges.size()), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("rpt_edge%0d", i),
            32'((i < right_edges.size()) ? right_edges[i] - base : -1), 32'(exp_rpt[i]));

    // Short release bounce pauses (does not restart) the repeat delay
    clear_counts();
    right_raw = 1'b1;
    base = e_now + 1;
    repeat (10) tick();
    right_raw = 1'b0;
    repeat (2) tick();
    right_raw = 1'b1;
    repeat (25) tick();
    idle_out(12);
    check("bnc_count", 32'(right_edges.size()), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("bnc_edge%0d", i),
            32'((i < right_edges.size()) ? right_edges[i] - base : -1), 32'(exp_bnc[i]));
`endif

    // Reset mid press-wait, recovery, then reset while a pulse is high
    clear_counts();
    left_raw = 1'b1;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("rpw_held", 32'(bus.held), 0);
    check("rpw_left", 32'(bus.left), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    base = e_now + 1;
    repeat (6) tick();
    check("rec_e5_left", 32'(bus.left), 0);
    check("rec_e5_held", 32'(bus.held), 3'b001);
    tick();
    check("rec_e6_left", 32'(bus.left), 1);
    #2 rst = 1'b1;
    #1;
    check("rh_left", 32'(bus.left), 0);
    check("rh_held", 32'(bus.held), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_out(12);
    check("rec_count", 32'(n_left), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
